// File: rtl/gray_code_receiver.sv
// Synchronises, glitch-filters and decodes an asynchronous Gray-coded bus, classifying
// each accepted change as +1, -1 or illegal. Optional macro: GRAY_RX_STRICT_EN.
module gray_code_receiver #(
  parameter int BITS          = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int STABLE_BITS   = 3,
  parameter int ERR_BITS      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BITS-1:0]     gray_in,
  output logic [BITS-1:0]     value,
  output logic                valid,
  output logic                step,
  output logic                dir,
  output logic                error,
  output logic [ERR_BITS-1:0] error_count
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  localparam logic [STABLE_BITS-1:0] STABLE_MAX = STABLE_BITS'(STABLE_CYCLES);
  localparam logic [STABLE_BITS-1:0] STABLE_ONE = STABLE_BITS'(1);
  localparam logic [BITS-1:0]        VAL_ONE    = BITS'(1);
  localparam logic [ERR_BITS-1:0]    ERR_ONE    = ERR_BITS'(1);
  localparam logic [ERR_BITS-1:0]    ERR_MAX    = '1;

  state_t                 state;
  logic [BITS-1:0]        sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] fill_q;
  logic [BITS-1:0]        cand;
  logic                   cand_valid;
  logic [STABLE_BITS-1:0] cnt;

  logic [BITS-1:0] sync_out;
  logic [BITS-1:0] dec;
  logic            primed;
  logic            match;
  logic            accept;
  logic            is_up;
  logic            is_down;

  // fill_q tracks which synchroniser stages hold post-reset samples, so the
  // filter never counts the cleared chain contents as a real input code.
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign primed   = fill_q[SYNC_STAGES-1];
  assign match    = primed && cand_valid && (sync_out == cand);
  assign accept   = match && (cnt == STABLE_MAX - STABLE_ONE);

  always_comb begin
    dec = '0;
    for (int i = 0; i < BITS; i++) begin
      dec[i] = ^(cand >> i);
    end
  end

  assign is_up   = (dec == value + VAL_ONE);
  assign is_down = (dec == value - VAL_ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      fill_q      <= '0;
      cand        <= '0;
      cand_valid  <= 1'b0;
      cnt         <= '0;
      state       <= UNLOCKED;
      value       <= '0;
      valid       <= 1'b0;
      step        <= 1'b0;
      dir         <= 1'b0;
      error       <= 1'b0;
      error_count <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      step   <= 1'b0;
      error  <= 1'b0;

      if (primed) begin
        if (!match) begin
          cand       <= sync_out;
          cand_valid <= 1'b1;
          cnt        <= '0;
        end else if (cnt != STABLE_MAX) begin
          cnt <= cnt + STABLE_ONE;
        end
      end

      if (accept) begin
        value <= dec;
        case (state)
          UNLOCKED: begin
            valid <= 1'b1;
            state <= LOCKED;
          end
          LOCKED: begin
            if (is_up || is_down) begin
              step <= 1'b1;
              dir  <= is_up;
            end else begin
              error <= 1'b1;
              if (error_count != ERR_MAX) error_count <= error_count + ERR_ONE;
`ifdef GRAY_RX_STRICT_EN
              valid <= 1'b0;
              state <= UNLOCKED;
`endif
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

endmodule
